// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the bit-serial arithmetic sequencers: FSM state
// encodings, opcodes and the counter sizing helper.
package serial_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit counter needs to reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_seq_fa_cell.sv
// Single-bit full adder built from two half adders and an OR; purely
// combinational, no flow control.
module ha_cell (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_cell (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic cin
);
  logic s0, c0, c1;

  ha_cell u_ha0 (.s(s0),  .c(c0), .a(a),  .b(b));
  ha_cell u_ha1 (.s(sum), .c(c1), .a(s0), .b(cin));

  assign carry = c0 | c1;
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract, LSB first, through one shared full-adder cell.
// Latency WIDTH+1 edges from accept to done; start is ignored while busy.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
  logic [WIDTH-1:0] psum_d;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;
  logic             fa_s, fa_c;

  fa_cell u_fa (
    .sum   (fa_s),
    .carry (fa_c),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q)
  );

  assign psum_d = {fa_s, psum_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert B and seed the carry with op.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{op}};
            carry_q <= (op == OP_SUB);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          psum_q  <= psum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // carry_q here is still the carry into the MSB.
            sum_q   <= psum_d;
            cout_q  <= fa_c;
            ovf_q   <= carry_q ^ fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboarded bench: WIDTH=4 directed vectors plus a WIDTH=8 model-checked
// regression; a negedge monitor pops expected results on every done pulse.
module tb_serial_add_seq;
  import serial_add_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start4, op4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic       start8, op8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] prev4 = '0;
  logic [7:0] prev8 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per done cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done4) begin
        if (q4.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done4_unexpected: got done=1 expected done=0 (t=%0t)", $time);
        end else begin
          e = q4.pop_front();
          check("sum4", sum4, e.s[3:0]);
          check("cout4", cout4, e.c);
          check("ovf4", ovf4, e.o);
        end
      end
      if (done8) begin
        if (q8.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL done8_unexpected: got done=1 expected done=0 (t=%0t)", $time);
        end else begin
          e = q8.pop_front();
          check("sum8", sum8, e.s);
          check("cout8", cout8, e.c);
          check("ovf8", ovf8, e.o);
        end
      end
    end
  end

  // Called #1 after the accept edge; checks busy span, latency and hold.
  task automatic wait4(input logic [3:0] es);
    int lat = 0;
    int bc  = 0;
    while (!done4 && lat < 20) begin
      bc += int'(busy4);
      check("sum4_hold", sum4, prev4[3:0]);
      @(posedge clk); #1;
      lat++;
    end
    check("lat4", lat, 4);
    check("busy4_cycles", bc, 4);
    prev4 = {4'h0, es};
  endtask

  task automatic run4(input logic opv, input logic [3:0] av, input logic [3:0] bv,
                      input logic [3:0] es, input logic ec, input logic eo);
    q4.push_back('{s: {4'h0, es}, c: ec, o: eo});
    @(negedge clk);
    start4 = 1'b1; op4 = opv; a4 = av; b4 = bv;
    @(posedge clk); #1;
    start4 = 1'b0; op4 = ~opv; a4 = ~av; b4 = ~bv;
    wait4(es);
  endtask

  task automatic run8(input logic opv, input logic [7:0] av, input logic [7:0] bv);
    logic [8:0] full;
    logic [7:0] s;
    logic c, o;
    int lat = 0;
    int bc  = 0;
    if (opv == OP_SUB) begin
      s = av - bv;
      c = (av >= bv);
      o = (av[7] != bv[7]) && (s[7] != av[7]);
    end else begin
      full = {1'b0, av} + {1'b0, bv};
      s = full[7:0];
      c = full[8];
      o = (av[7] == bv[7]) && (s[7] != av[7]);
    end
    q8.push_back('{s: s, c: c, o: o});
    @(negedge clk);
    start8 = 1'b1; op8 = opv; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom);
    while (!done8 && lat < 40) begin
      bc += int'(busy8);
      check("sum8_hold", sum8, prev8);
      @(posedge clk); #1;
      lat++;
    end
    check("lat8", lat, 8);
    check("busy8_cycles", bc, 8);
    prev8 = s;
  endtask

  initial begin
    #2ms;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n;
    rst = 1'b1;
    start4 = 1'b1; op4 = 1'b0; a4 = 4'h3; b4 = 4'h3;
    start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_sum4", sum4, 0);
    check("rst_cout4", cout4, 0);
    check("rst_ovf4", ovf4, 0);
    check("rst_busy8", busy8, 0);
    check("rst_sum8", sum8, 0);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run4(OP_ADD, 4'h5, 4'h3, 4'h8, 1'b0, 1'b1);
    run4(OP_SUB, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0);
    run4(OP_SUB, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0);
    run4(OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
    run4(OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1);
    repeat (2) @(posedge clk);

    // start held high and operands churning throughout RUN.
    q4.push_back('{s: 8'h0B, c: 1'b0, o: 1'b0});
    @(negedge clk);
    start4 = 1'b1; op4 = OP_SUB; a4 = 4'h2; b4 = 4'h7;
    @(posedge clk);
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
      if (!done4) begin
        a4 = 4'($urandom); b4 = 4'($urandom); op4 = 1'($urandom);
      end
    end
    check("hold_lat", n, 5);
    prev4 = 8'h0B;
    q4.push_back('{s: 8'h0C, c: 1'b0, o: 1'b1});
    op4 = OP_ADD; a4 = 4'h6; b4 = 4'h6;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("accept_in_done", busy4, 1);
    wait4(4'hC);

    // Abort in the second RUN cycle.
    @(negedge clk);
    start4 = 1'b1; op4 = OP_ADD; a4 = 4'h1; b4 = 4'h1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy4", busy4, 0);
    check("abort_done4", done4, 0);
    check("abort_sum4", sum4, 0);
    check("abort_cout4", cout4, 0);
    check("abort_ovf4", ovf4, 0);
    prev4 = '0;
    prev8 = '0;
    repeat (3) @(posedge clk);
    run4(OP_SUB, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1);

    run8(OP_ADD, 8'h7F, 8'h01);
    run8(OP_SUB, 8'h80, 8'h01);
    run8(OP_ADD, 8'hFF, 8'hFF);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run8(1'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    check("q4_drained", q4.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial add/subtract sequencer that time-shares one full-adder cell across all operand bits, LSB first, one bit per clock. It sits between a requester with a start/done handshake and the gate-level full-adder datapath, and supplies the cell's operand bits, carry feedback and result collection. It trades WIDTH cycles of latency for a single adder cell.

## Interface

- WIDTH, 4, operand and result width in bits; legal range WIDTH ≥ 2.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- op  in  1  operation select: 0 = add (a + b), 1 = subtract (a − b). Sampled with start.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; high in the DONE cycle.
- sum  out  WIDTH  result. Held until the next completion.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement overflow of the result.

## Operation

- Reset gives: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, bit counter 0, and all internal shift and carry registers 0.
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - If start = 1 on an edge:
    - latch a into shift register A;
    - latch b XOR {WIDTH{op}} into shift register B;
    - set the carry register to op, which forms the two's-complement subtract;
    - clear the counter;
    - go to RUN.
  - If start = 0, remain in IDLE.
- **RUN**, one bit per edge:
  - Drive the cell with s, c = FA(A[0], B[0], carry).
  - Shift the partial-sum register right, inserting s at the MSB.
  - Shift A and B right.
  - Load carry with c.
  - Increment the counter.
  - On the edge where counter = WIDTH−1, also:
    - write sum from the final partial-sum value including this edge's s;
    - write cout from this edge's c;
    - write ovf as the carry into the MSB XOR the carry out of the MSB;
    - go to DONE.
- **DONE**
  - done = 1 for this cycle.
  - If start = 1, accept a new request exactly as IDLE does and go to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored. Changes on a, b or op after the accept edge have no effect.
- sum, cout and ovf change only on the completion edge or on reset. They are never visible mid-computation.
- Arithmetic is modulo 2^WIDTH. The carry into the MSB is the carry register value before the last RUN edge.
- Reset mid-operation aborts the operation, returns the FSM to IDLE, and clears the outputs as listed above. No done pulse is produced.

## Timing

- Every output is a registered state bit; there is no combinational path from input to output.
- start is accepted on edge E0.
- busy = 1 from after E0 through after E(WIDTH−1); the FSM spends WIDTH cycles in RUN.
- Results are written and done rises after edge E(WIDTH). done falls after edge E(WIDTH+1).
- Throughput is one operation per WIDTH+1 cycles when start is accepted in DONE. When the FSM returns through IDLE, throughput is one per WIDTH+2 cycles.
- If rst and start are high on the same edge, rst wins.

## Structure

- **Shared definitions file**:
  - state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - opcode constants: OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Both are reused by the testbench and by future serial multiplier controllers.
- **Counter width**: $clog2(WIDTH) bits, with a minimum of 1.
- **Sub-module fa_cell**: the single-bit full adder.
  - Ports: sum out, carry out, a, b, cin.
  - Built structurally from the team's gate-level half-adder primitives.
  - Instantiated exactly once.
- **Controller**: serial_add_seq holds the FSM, counter, shift registers, carry register and result registers.

## Test plan

- **Add with signed overflow.** WIDTH=4, op=0, a=5, b=3, start pulse → done high 5 edges after accept; sum=8, cout=0, ovf=1; busy high for exactly 4 cycles.
- **Subtract with borrow.** op=1, a=3, b=5 → sum=4'hE, cout=0, ovf=0. Then a=5, b=3 → sum=2, cout=1, ovf=0.
- **Unsigned carry out.** op=0, a=4'hF, b=4'h1 → sum=0, cout=1, ovf=0. Then a=4'h7, b=4'h1 → sum=8, ovf=1.
- **Inputs ignored while running.** Hold start=1 and change a, b and op every cycle during RUN → the result matches the operands sampled at accept. A new operation is accepted only in the DONE cycle, and the next done follows 5 edges later.
- **Reset mid-operation.** Assert rst in the 2nd RUN cycle → on the next cycle state is IDLE and busy, done, sum, cout and ovf are all 0, with no done pulse. A subsequent request completes correctly.
- **Randomised regression.** WIDTH=8, 1000 random requests with random idle gaps, compared against a behavioural model (a ± b, carry, overflow) → zero mismatches; sum holds between completions.
